// File: rtl/csa_mult_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential carry-save multiplier.
// The master side supplies operands and accepts products; the slave side is the multiplier.
interface csa_mult_seq_ctrl_if #(
   parameter int MAX_MLTCND_BITS = 12,
   parameter int MAX_MLTPLR_BITS = 9
);
   logic                                       in_valid;
   logic                                       in_ready;
   logic [MAX_MLTCND_BITS-1:0]                 mltcnd;
   logic [MAX_MLTPLR_BITS-1:0]                 mltplr;
   logic                                       abort;
   logic                                       out_valid;
   logic                                       out_ready;
   logic [MAX_MLTCND_BITS+MAX_MLTPLR_BITS-1:0] mult_out;
   logic                                       busy;

   modport master (
      output in_valid, mltcnd, mltplr, abort, out_ready,
      input  in_ready, out_valid, mult_out, busy
   );

   modport slave (
      input  in_valid, mltcnd, mltplr, abort, out_ready,
      output in_ready, out_valid, mult_out, busy
   );
endinterface

// File: rtl/csa_mult_seq_ctrl.sv
// Sequential unsigned multiplier: one reused carry-save row folds a multiplier bit per cycle,
// then a single carry-propagate add resolves the redundant sum/carry pair.
module csa_mult_seq_ctrl #(
   parameter int MAX_MLTCND_BITS = 12,
   parameter int MAX_MLTPLR_BITS = 9
) (
   input logic                clk,
   input logic                rst_n,
   csa_mult_seq_ctrl_if.slave bus
);
   localparam int M  = MAX_MLTCND_BITS;
   localparam int N  = MAX_MLTPLR_BITS;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

   state_t          state;
   state_t          state_next;
   logic [M-1:0]    a;
   logic [M-1:0]    s;
   logic [M-1:0]    c;
   logic [N-1:0]    b;
   logic [N-1:0]    p_lo;
   logic [CW-1:0]   cnt;
   logic [M+N-1:0]  mult_q;

   logic [M-1:0]    pp;
   logic [M-1:0]    s_half;
   logic [M-1:0]    s_next;
   logic [M-1:0]    c_next;
   logic [M-1:0]    upper;
   logic [M+N-1:0]  product;
   logic            accept;
   logic            last;

   assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == ACCUM) || (state == RESOLVE);
   assign bus.mult_out  = mult_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign last   = (cnt == CW'(N - 1));

   // S is realigned one place right each cycle while C keeps its position, so the
   // upper half of the product never exceeds M bits and the final add cannot carry out.
   always_comb begin
      pp      = b[0] ? a : '0;
      s_half  = {1'b0, s[M-1:1]};
      s_next  = pp ^ s_half ^ c;
      c_next  = (pp & s_half) | (pp & c) | (s_half & c);
      upper   = s_half + c;
      product = {upper, s[0], p_lo[N-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = ACCUM;
         ACCUM: begin
            if (bus.abort)  state_next = IDLE;
            else if (last)  state_next = RESOLVE;
         end
         RESOLVE: state_next = bus.abort ? IDLE : DONE;
         DONE: begin
            if (bus.out_ready) state_next = accept ? ACCUM : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The result register only changes on a completed RESOLVE, so it holds through IDLE and aborts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a      <= '0;
         b      <= '0;
         s      <= '0;
         c      <= '0;
         p_lo   <= '0;
         cnt    <= '0;
         mult_q <= '0;
      end else begin
         if (accept) begin
            a    <= bus.mltcnd;
            b    <= bus.mltplr;
            s    <= '0;
            c    <= '0;
            p_lo <= '0;
            cnt  <= '0;
         end else if ((state == ACCUM) && !bus.abort) begin
            s    <= s_next;
            c    <= c_next;
            p_lo <= {s[0], p_lo[N-1:1]};
            b    <= b >> 1;
            cnt  <= cnt + CW'(1);
         end
         if ((state == RESOLVE) && !bus.abort) begin
            mult_q <= product;
         end
      end
   end
endmodule

// File: tb/tb_csa_mult_seq_ctrl.sv
// Self-checking bench for csa_mult_seq_ctrl: directed corner cases plus randomized
// operations scored against a plain-arithmetic product queue.
module tb_csa_mult_seq_ctrl;
   localparam int M = 12;
   localparam int N = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   csa_mult_seq_ctrl_if #(.MAX_MLTCND_BITS(M), .MAX_MLTPLR_BITS(N)) bus ();

   csa_mult_seq_ctrl #(.MAX_MLTCND_BITS(M), .MAX_MLTPLR_BITS(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int               checkCount = 0;
   int               errorCount = 0;
   longint unsigned  expQ[$];
   logic [63:0]      lastProduct = '0;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an operand pair and wait for the accepting edge; the expected product is queued.
   task automatic applyStimulus(input logic [M-1:0] mc, input logic [N-1:0] mp, input bit keepValid);
      bit acc = 1'b0;
      int waitCyc = 0;
      bus.in_valid = 1'b1;
      bus.mltcnd   = mc;
      bus.mltplr   = mp;
      while (!acc && waitCyc < 200) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         waitCyc++;
      end
      if (!acc) checkOutput("accept_timeout", 64'(acc), 64'(1));
      else expQ.push_back(64'(mc) * 64'(mp));
      if (!keepValid) begin
         bus.in_valid = 1'b0;
         bus.mltcnd   = M'($urandom);
         bus.mltplr   = N'($urandom);
      end
   endtask

   task automatic waitResult(input string tag, input bit randReady);
      int cyc = 0;
      int busyCyc = 0;
      logic [63:0] expected;
      while (!bus.out_valid && cyc < 100) begin
         if (bus.busy) busyCyc++;
         if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      checkOutput({tag, "_latency"}, 64'(cyc), 64'(N + 1));
      checkOutput({tag, "_busy_cycles"}, 64'(busyCyc), 64'(N + 1));
      expected = (expQ.size() > 0) ? expQ.pop_front() : '1;
      checkOutput({tag, "_product"}, 64'(bus.mult_out), expected);
      lastProduct = expected;
   endtask

   // Stall the consumer for holdCycles with a competing in_valid, then take the result.
   task automatic releaseResult(input int holdCycles, input string tag);
      logic [M+N-1:0] held = bus.mult_out;
      for (int h = 0; h < holdCycles; h++) begin
         bus.out_ready = 1'b0;
         bus.in_valid  = 1'b1;
         #1;
         checkOutput({tag, "_stall_in_ready"}, 64'(bus.in_ready), 64'(0));
         tick();
         checkOutput({tag, "_stall_valid"}, 64'(bus.out_valid), 64'(1));
         checkOutput({tag, "_stall_hold"}, 64'(bus.mult_out), 64'(held));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      checkOutput({tag, "_released"}, 64'(bus.out_valid), 64'(0));
      if (holdCycles > 0) checkOutput({tag, "_no_stray_accept"}, 64'(bus.busy), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checkCount, errorCount);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [M-1:0] mc;
      logic [N-1:0] mp;
      int seen;
      logic [M-1:0] tblMc [4] = '{12'h800, 12'h000, 12'h001, 12'h5A5};
      logic [N-1:0] tblMp [4] = '{9'h100, 9'h1FF, 9'h001, 9'h0C3};

      bus.in_valid  = 1'b0;
      bus.mltcnd    = '0;
      bus.mltplr    = '0;
      bus.abort     = 1'b0;
      bus.out_ready = 1'b1;
      #12;
      checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(1));
      checkOutput("reset_out_valid", 64'(bus.out_valid), 64'(0));
      checkOutput("reset_busy", 64'(bus.busy), 64'(0));
      checkOutput("reset_mult_out", 64'(bus.mult_out), 64'(0));
      #5 rst_n = 1'b1;
      tick();

      $display("[TB] full-scale operands");
      applyStimulus(12'hFFF, 9'h1FF, 1'b0);
      waitResult("max", 1'b0);
      checkOutput("max_literal", 64'(bus.mult_out), 64'h1FEE01);
      releaseResult(0, "max");

      $display("[TB] directed table");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(tblMc[i], tblMp[i], 1'b0);
         waitResult("table", 1'b0);
         releaseResult((i == 3) ? 5 : 0, "table");
      end

      $display("[TB] back-to-back accept on DONE edge");
      applyStimulus(12'h123, 9'h045, 1'b1);
      bus.mltcnd = 12'hABC;
      bus.mltplr = 9'h1A5;
      waitResult("b2b_first", 1'b0);
      #1;
      checkOutput("b2b_done_in_ready", 64'(bus.in_ready), 64'(1));
      tick();
      expQ.push_back(64'(12'hABC) * 64'(9'h1A5));
      bus.in_valid = 1'b0;
      checkOutput("b2b_restart_busy", 64'(bus.busy), 64'(1));
      checkOutput("b2b_restart_valid", 64'(bus.out_valid), 64'(0));
      waitResult("b2b_second", 1'b0);
      releaseResult(0, "b2b");

      $display("[TB] abort in ACCUM");
      applyStimulus(12'hFFF, 9'h1FF, 1'b0);
      void'(expQ.pop_back());
      repeat (4) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checkOutput("abort_busy", 64'(bus.busy), 64'(0));
      checkOutput("abort_in_ready", 64'(bus.in_ready), 64'(1));
      checkOutput("abort_mult_out_held", 64'(bus.mult_out), lastProduct);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.out_valid) seen++;
         tick();
      end
      checkOutput("abort_no_valid", 64'(seen), 64'(0));
      applyStimulus(12'h003, 9'h005, 1'b0);
      waitResult("after_abort", 1'b0);
      releaseResult(0, "after_abort");

      $display("[TB] abort with in_valid in IDLE");
      bus.abort = 1'b1;
      applyStimulus(12'h0A5, 9'h033, 1'b0);
      bus.abort = 1'b0;
      waitResult("idle_abort", 1'b0);
      releaseResult(0, "idle_abort");

      $display("[TB] asynchronous reset during ACCUM");
      applyStimulus(12'h777, 9'h1AB, 1'b0);
      void'(expQ.pop_back());
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("areset_in_ready", 64'(bus.in_ready), 64'(1));
      checkOutput("areset_busy", 64'(bus.busy), 64'(0));
      checkOutput("areset_out_valid", 64'(bus.out_valid), 64'(0));
      checkOutput("areset_mult_out", 64'(bus.mult_out), 64'(0));
      #3 rst_n = 1'b1;
      tick();
      applyStimulus(12'h0FF, 9'h0FF, 1'b0);
      waitResult("after_reset", 1'b0);
      releaseResult(0, "after_reset");

      $display("[TB] randomized operations");
      for (int k = 0; k < 600; k++) begin
         repeat ($urandom_range(0, 2)) begin
            bus.mltcnd = M'($urandom);
            bus.mltplr = N'($urandom);
            tick();
         end
         case ($urandom_range(0, 7))
            0:       mc = '0;
            1:       mc = '1;
            default: mc = M'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0:       mp = '0;
            1:       mp = '1;
            default: mp = N'($urandom);
         endcase
         applyStimulus(mc, mp, 1'b0);
         waitResult("rand", 1'b1);
         releaseResult($urandom_range(0, 2), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end
endmodule
